// File: rtl/uart_tx_if.sv
// Handshake bundle between the transmit requester (master) and uart_tx (slave).
interface uart_tx_if #(
  parameter int BIT_MAX = 8
);
  logic               tx_start;
  logic [BIT_MAX-1:0] tx_data;
  logic               tx_busy;
  logic               tx_done;

  modport master (output tx_start, output tx_data, input tx_busy, input tx_done);
  modport slave  (input tx_start, input tx_data, output tx_busy, output tx_done);
endinterface

// File: rtl/uart_tx.sv
// UART transmitter: one BIT_MAX-bit word per accepted request, LSB first, 8N1 framing.
// Define UART_TX_PARITY_EN to insert an even-parity bit between DATA and STOP (8E1).
module uart_tx #(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = 115200,
  parameter int BIT_MAX  = 8
) (
  input  logic     clk,
  input  logic     rst,
  uart_tx_if.slave bus,
  output logic     txd
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IDX_W        = (BIT_MAX > 1) ? $clog2(BIT_MAX) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(BIT_MAX - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
  localparam logic [IDX_W-1:0] IDX_ZERO = IDX_W'(0);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_e;

  function automatic logic even_parity(input logic [BIT_MAX-1:0] word);
    return ^word;
  endfunction
`else
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd4
  } state_e;
`endif

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [BIT_MAX-1:0] shift_q, shift_d;
  logic               txd_q, txd_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               bit_end_s;
`ifdef UART_TX_PARITY_EN
  logic               parity_q, parity_d;
`endif

  assign bit_end_s   = (cnt_q == CNT_LAST);
  assign txd         = txd_q;
  assign bus.tx_busy = busy_q;
  assign bus.tx_done = done_q;

  // Next-state and next-output logic; txd_d is the level of the bit the FSM moves into.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    shift_d  = shift_q;
    txd_d    = txd_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_d = parity_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.tx_start && !busy_q) begin
          state_d  = S_START;
          cnt_d    = CNT_ZERO;
          idx_d    = IDX_ZERO;
          shift_d  = bus.tx_data;
          txd_d    = 1'b0;
          busy_d   = 1'b1;
`ifdef UART_TX_PARITY_EN
          parity_d = even_parity(bus.tx_data);
`endif
        end else begin
          txd_d  = 1'b1;
          busy_d = 1'b0;
        end
      end
      S_START: begin
        if (bit_end_s) begin
          state_d = S_DATA;
          cnt_d   = CNT_ZERO;
          txd_d   = shift_q[0];
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_DATA: begin
        if (bit_end_s) begin
          cnt_d = CNT_ZERO;
          if (idx_q == IDX_LAST) begin
`ifdef UART_TX_PARITY_EN
            state_d = S_PARITY;
            txd_d   = parity_q;
`else
            state_d = S_STOP;
            txd_d   = 1'b1;
`endif
          end else begin
            idx_d   = idx_q + IDX_ONE;
            shift_d = shift_q >> 1'b1;
            txd_d   = shift_d[0];
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (bit_end_s) begin
          state_d = S_STOP;
          cnt_d   = CNT_ZERO;
          txd_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
`endif
      S_STOP: begin
        if (bit_end_s) begin
          state_d = S_IDLE;
          cnt_d   = CNT_ZERO;
          txd_d   = 1'b1;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = CNT_ZERO;
        idx_d   = IDX_ZERO;
        txd_d   = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and registered outputs; reset aborts any frame in flight with the line idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= CNT_ZERO;
      idx_q    <= IDX_ZERO;
      shift_q  <= {BIT_MAX{1'b0}};
      txd_q    <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      shift_q  <= shift_d;
      txd_q    <= txd_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
`ifdef UART_TX_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

endmodule
